// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: one WIDTH-bit ripple adder is reused
// over WIDTH steps, with valid/ready handshakes on operand and product sides.

module full_adder_wcarry_nbits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];
endmodule

module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic               busy_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Partial product is gated by the current low multiplier bit.
    assign addend = acc_lo_reg[0] ? mcand_reg : '0;

    full_adder_wcarry_nbits #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a    (acc_hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            p_o         <= '0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        mcand_reg  <= a_i;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= b_i;
                        cnt_reg    <= '0;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    // Carry-out lands in the accumulator MSB as everything shifts right.
                    {acc_hi_reg, acc_lo_reg} <= {cout, sum, acc_lo_reg[WIDTH-1:1]};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_STEP) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_o) begin
                        out_valid_o <= 1'b1;
                        p_o         <= {acc_hi_reg, acc_lo_reg};
                    end else if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule
